// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the timer_ctrl block.
//   CNT_W_DEF      default width of the period register and count
//   timer_state_e  FSM state encoding (IDLE, RUN, PAUSED, DONE)
//   is_armable()   true in the states where a fresh run may be armed
package timer_pkg;

    localparam int unsigned CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StPaused = 2'd2,
        StDone   = 2'd3
    } timer_state_e;

    // Period writes and fresh starts are only honoured while no run is in flight.
    function automatic logic is_armable(timer_state_e s);
        return (s == StIdle) || (s == StDone);
    endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if: control/status bundle of timer_ctrl.
//   i_start, i_stop, i_clear  run-control pulses
//   i_mode                    0 = one-shot, 1 = periodic
//   i_period_wr, i_period     period register write
//   i_irq_ack                 clears o_irq
//   o_count                   current count
//   o_enable, o_busy          RUN / (RUN or PAUSED) status
//   o_irq, o_overrun          sticky event flags
// Signal names are from the timer's point of view; the slave modport is the timer.
interface timer_ctrl_if
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    logic             i_start;
    logic             i_stop;
    logic             i_clear;
    logic             i_mode;
    logic             i_period_wr;
    logic [CNT_W-1:0] i_period;
    logic             i_irq_ack;
    logic [CNT_W-1:0] o_count;
    logic             o_enable;
    logic             o_busy;
    logic             o_irq;
    logic             o_overrun;

    modport master (
        output i_start, i_stop, i_clear, i_mode, i_period_wr, i_period, i_irq_ack,
        input  o_count, o_enable, o_busy, o_irq, o_overrun
    );

    modport slave (
        input  i_start, i_stop, i_clear, i_mode, i_period_wr, i_period, i_irq_ack,
        output o_count, o_enable, o_busy, o_irq, o_overrun
    );

endinterface

// File: rtl/counter_clr.sv
// counter_clr: CNT_W up-counter with enable and synchronous clear.
//   i_clk    clock, rising edge
//   i_rstn   asynchronous active-low reset
//   i_en     increment this cycle
//   i_clr    zero the count on the next edge (wins over i_en)
//   o_count  registered count
module counter_clr
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: one-shot / periodic timer with pause, abort and sticky interrupt.
//   i_clk   clock, rising edge
//   i_rstn  asynchronous active-low reset
//   bus     timer_ctrl_if.slave: start/stop/clear/mode, period write, irq ack in;
//           count, enable, busy, irq, overrun out (all registered)
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    timer_ctrl_if.slave  bus
);

    timer_state_e     r_state;
    timer_state_e     w_state_d;
    logic [CNT_W-1:0] r_period;
    logic             r_mode;
    logic             r_enable;
    logic             r_busy;
    logic             r_irq;
    logic             r_overrun;

    logic [CNT_W-1:0] w_count;
    logic             w_terminal;
    logic             w_event;
    logic             w_adv;
    logic             w_cnt_clr;
    logic             w_mode_ld;
    logic             w_irq_d;
    logic             w_overrun_d;

    // The count never exceeds P-1, so equality with P-1 marks the terminal cycle.
    assign w_terminal = (r_state == StRun) && (w_count == (r_period - CNT_W'(1)));

    // Priority: clear, stop, start, terminal advance.
    always_comb begin
        w_state_d = r_state;
        w_adv     = 1'b0;
        w_cnt_clr = 1'b0;
        w_mode_ld = 1'b0;
        w_event   = 1'b0;
        if (bus.i_clear) begin
            w_state_d = StIdle;
            w_cnt_clr = 1'b1;
        end else begin
            case (r_state)
                StRun: begin
                    if (bus.i_stop) begin
                        w_state_d = StPaused;
                    end else if (w_terminal) begin
                        w_event = 1'b1;
                        if (r_mode) begin
                            w_cnt_clr = 1'b1;
                        end else begin
                            // One-shot holds the count at P-1.
                            w_state_d = StDone;
                        end
                    end else begin
                        w_adv = 1'b1;
                    end
                end
                StPaused: begin
                    if (bus.i_start) begin
                        w_state_d = StRun;
                    end
                end
                StIdle, StDone: begin
                    if (bus.i_start && (r_period != '0)) begin
                        w_state_d = StRun;
                        w_cnt_clr = 1'b1;
                        w_mode_ld = 1'b1;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                    w_cnt_clr = 1'b1;
                end
            endcase
        end
    end

    // An ack coinciding with an event loses to the event; overrun needs an
    // unacknowledged pending irq.
    always_comb begin
        w_irq_d     = r_irq;
        w_overrun_d = r_overrun;
        if (bus.i_clear) begin
            w_irq_d     = 1'b0;
            w_overrun_d = 1'b0;
        end else if (w_event) begin
            w_irq_d = 1'b1;
            if (r_irq && !bus.i_irq_ack) begin
                w_overrun_d = 1'b1;
            end
        end else if (bus.i_irq_ack) begin
            w_irq_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state   <= StIdle;
            r_period  <= '0;
            r_mode    <= 1'b0;
            r_enable  <= 1'b0;
            r_busy    <= 1'b0;
            r_irq     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_enable  <= (w_state_d == StRun);
            r_busy    <= (w_state_d == StRun) || (w_state_d == StPaused);
            r_irq     <= w_irq_d;
            r_overrun <= w_overrun_d;
            if (is_armable(r_state) && bus.i_period_wr) begin
                r_period <= bus.i_period;
            end
            if (w_mode_ld) begin
                r_mode <= bus.i_mode;
            end
        end
    end

    counter_clr #(
        .CNT_W (CNT_W)
    ) u_counter (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_en    (r_enable & w_adv),
        .i_clr   (w_cnt_clr),
        .o_count (w_count)
    );

    assign bus.o_count   = w_count;
    assign bus.o_enable  = r_enable;
    assign bus.o_busy    = r_busy;
    assign bus.o_irq     = r_irq;
    assign bus.o_overrun = r_overrun;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed scoreboard bench for timer_ctrl.
// Each step pushes the expected {count, enable, busy, irq, overrun} before the
// clock edge; the entry is popped and compared once the edge has produced it.
module tb_timer_ctrl;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned VW    = CNT_W + 4;

    typedef struct {
        string         tag;
        logic [VW-1:0] vec;
    } exp_t;

    logic i_clk;
    logic i_rstn;
    exp_t sb[$];
    int   n_vec;
    int   n_err;

    timer_ctrl_if #(.CNT_W(CNT_W)) bus ();

    timer_ctrl #(
        .CNT_W (CNT_W)
    ) dut (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .bus    (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic push(input string tag, input int cnt, input bit en, input bit busy,
                        input bit irq, input bit ovr);
        exp_t e;
        e.tag = tag;
        e.vec = {CNT_W'(cnt), en, busy, irq, ovr};
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t          e;
        logic [VW-1:0] obs;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_empty observed=none expected=entry");
            return;
        end
        e   = sb.pop_front();
        obs = {bus.o_count, bus.o_enable, bus.o_busy, bus.o_irq, bus.o_overrun};
        n_vec++;
        assert (obs === e.vec) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h (count,en,busy,irq,ovr)", e.tag, obs, e.vec);
        end
    endtask

    // One clock: expectation pushed, edge taken, pulses dropped, result compared.
    task automatic cyc(input string tag, input int cnt, input bit en, input bit busy,
                       input bit irq, input bit ovr);
        push(tag, cnt, en, busy, irq, ovr);
        @(posedge i_clk);
        #1;
        bus.i_start     = 1'b0;
        bus.i_stop      = 1'b0;
        bus.i_clear     = 1'b0;
        bus.i_period_wr = 1'b0;
        bus.i_irq_ack   = 1'b0;
        check();
    endtask

    task automatic wr_period(input int p);
        bus.i_period_wr = 1'b1;
        bus.i_period    = CNT_W'(p);
    endtask

    task automatic start(input bit mode);
        bus.i_start = 1'b1;
        bus.i_mode  = mode;
    endtask

    initial begin
        n_vec           = 0;
        n_err           = 0;
        i_rstn          = 1'b0;
        bus.i_start     = 1'b0;
        bus.i_stop      = 1'b0;
        bus.i_clear     = 1'b0;
        bus.i_mode      = 1'b0;
        bus.i_period_wr = 1'b0;
        bus.i_period    = '0;
        bus.i_irq_ack   = 1'b0;
        #1;
        push("reset", 0, 0, 0, 0, 0);
        check();
        repeat (2) @(posedge i_clk);
        #1;
        i_rstn = 1'b1;

        // P=4 periodic: 0,1,2,3,0,... with an event every 4 cycles.
        wr_period(4);
        cyc("p4_wr", 0, 0, 0, 0, 0);
        start(1'b1);
        cyc("p4_start", 0, 1, 1, 0, 0);
        cyc("p4_c1", 1, 1, 1, 0, 0);
        cyc("p4_c2", 2, 1, 1, 0, 0);
        cyc("p4_c3", 3, 1, 1, 0, 0);
        cyc("p4_ev1", 0, 1, 1, 1, 0);
        bus.i_irq_ack = 1'b1;
        cyc("p4_ack", 1, 1, 1, 0, 0);
        cyc("p4_c2b", 2, 1, 1, 0, 0);
        cyc("p4_c3b", 3, 1, 1, 0, 0);
        cyc("p4_ev2", 0, 1, 1, 1, 0);
        bus.i_clear = 1'b1;
        cyc("p4_clear", 0, 0, 0, 0, 0);

        // P=3 one-shot: DONE at count 2; rerun without rewrite.
        wr_period(3);
        cyc("p3_wr", 0, 0, 0, 0, 0);
        start(1'b0);
        cyc("p3_start", 0, 1, 1, 0, 0);
        cyc("p3_c1", 1, 1, 1, 0, 0);
        cyc("p3_c2", 2, 1, 1, 0, 0);
        cyc("p3_done", 2, 0, 0, 1, 0);
        cyc("p3_hold", 2, 0, 0, 1, 0);
        bus.i_stop = 1'b1;
        cyc("p3_stop_done", 2, 0, 0, 1, 0);
        start(1'b0);
        bus.i_irq_ack = 1'b1;
        cyc("p3_restart", 0, 1, 1, 0, 0);
        wr_period(7);
        cyc("p3_wr_in_run", 1, 1, 1, 0, 0);
        cyc("p3_r_c2", 2, 1, 1, 0, 0);
        cyc("p3_done2", 2, 0, 0, 1, 0);
        bus.i_clear = 1'b1;
        cyc("p3_clear", 0, 0, 0, 0, 0);

        // P=5: stop in the terminal cycle wins; event on the first RUN cycle after resume.
        wr_period(5);
        cyc("p5_wr", 0, 0, 0, 0, 0);
        start(1'b1);
        cyc("p5_start", 0, 1, 1, 0, 0);
        cyc("p5_c1", 1, 1, 1, 0, 0);
        cyc("p5_c2", 2, 1, 1, 0, 0);
        cyc("p5_c3", 3, 1, 1, 0, 0);
        cyc("p5_c4", 4, 1, 1, 0, 0);
        bus.i_stop = 1'b1;
        cyc("p5_pause", 4, 0, 1, 0, 0);
        cyc("p5_paused", 4, 0, 1, 0, 0);
        start(1'b1);
        cyc("p5_resume", 4, 1, 1, 0, 0);
        cyc("p5_ev", 0, 1, 1, 1, 0);
        start(1'b0);
        cyc("p5_start_in_run", 1, 1, 1, 1, 0);
        bus.i_clear = 1'b1;
        cyc("p5_clear", 0, 0, 0, 0, 0);

        // P=2 periodic, never acked: overrun after the second event.
        wr_period(2);
        cyc("p2_wr", 0, 0, 0, 0, 0);
        start(1'b1);
        cyc("p2_start", 0, 1, 1, 0, 0);
        cyc("p2_c1", 1, 1, 1, 0, 0);
        cyc("p2_ev1", 0, 1, 1, 1, 0);
        cyc("p2_c1b", 1, 1, 1, 1, 0);
        cyc("p2_ovr", 0, 1, 1, 1, 1);
        bus.i_clear = 1'b1;
        cyc("p2_clear", 0, 0, 0, 0, 0);

        // Period kept across clear; ack coinciding with an event keeps irq, no overrun.
        start(1'b1);
        cyc("p2b_start", 0, 1, 1, 0, 0);
        cyc("p2b_c1", 1, 1, 1, 0, 0);
        cyc("p2b_ev1", 0, 1, 1, 1, 0);
        cyc("p2b_c1b", 1, 1, 1, 1, 0);
        bus.i_irq_ack = 1'b1;
        cyc("p2b_ack_ev", 0, 1, 1, 1, 0);
        bus.i_clear = 1'b1;
        cyc("p2b_clear", 0, 0, 0, 0, 0);

        // P=1 periodic: count stays 0, event every cycle.
        wr_period(1);
        cyc("p1_wr", 0, 0, 0, 0, 0);
        start(1'b1);
        cyc("p1_start", 0, 1, 1, 0, 0);
        cyc("p1_ev1", 0, 1, 1, 1, 0);
        bus.i_irq_ack = 1'b1;
        cyc("p1_ack_ev", 0, 1, 1, 1, 0);
        cyc("p1_ovr", 0, 1, 1, 1, 1);
        bus.i_clear = 1'b1;
        cyc("p1_clear", 0, 0, 0, 0, 0);

        // P=0: start ignored.
        wr_period(0);
        cyc("p0_wr", 0, 0, 0, 0, 0);
        start(1'b1);
        cyc("p0_start", 0, 0, 0, 0, 0);
        cyc("p0_idle", 0, 0, 0, 0, 0);

        // P=10: asynchronous reset mid-RUN, then start without a rewrite is ignored.
        wr_period(10);
        cyc("p10_wr", 0, 0, 0, 0, 0);
        start(1'b0);
        cyc("p10_start", 0, 1, 1, 0, 0);
        cyc("p10_c1", 1, 1, 1, 0, 0);
        cyc("p10_c2", 2, 1, 1, 0, 0);
        #2;
        i_rstn = 1'b0;
        #1;
        push("p10_async_rst", 0, 0, 0, 0, 0);
        check();
        @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
        start(1'b0);
        cyc("p10_post_rst", 0, 0, 0, 0, 0);
        cyc("p10_idle", 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
